// File: rtl/axis_lfsr_checker_pkg.sv
// Shared definitions for the LFSR checker: register map, reset values, FSM states and
// the LFSR next-state function also used by the generator.
package axis_lfsr_checker_pkg;

    localparam logic [7:0] AddrCtrl      = 8'h00;
    localparam logic [7:0] AddrTaps      = 8'h04;
    localparam logic [7:0] AddrStatus    = 8'h08;
    localparam logic [7:0] AddrSampleCnt = 8'h0C;
    localparam logic [7:0] AddrErrCnt    = 8'h10;
    localparam logic [7:0] AddrPeriod    = 8'h14;
    localparam logic [7:0] AddrLastData  = 8'h18;

    localparam logic [7:0] TapsReset = 8'hB8;
    localparam logic [1:0] RespOkay  = 2'b00;

    typedef enum logic [1:0] {StIdle, StArm, StTrack} chk_state_e;

    // Shift left, feed back the parity of the tapped bits into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] d, input logic [7:0] taps);
        return {d[6:0], ^(taps & d)};
    endfunction

endpackage

// File: rtl/axis_lfsr_checker_axil_reg_slave.sv
// AXI-Lite slave for the LFSR checker: single-outstanding write and read channels,
// control/taps registers and a read mux over the checker's status and counters.
module axil_reg_slave
    import axis_lfsr_checker_pkg::*;
#(
    parameter int unsigned C_AXIL_ADDR_WIDTH = 5,
    parameter int unsigned C_AXIL_DATA_WIDTH = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [C_AXIL_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [C_AXIL_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic                         locked,
    input  logic                         first_seen,
    input  logic                         err_sticky,
    input  logic [31:0]                  sample_cnt,
    input  logic [31:0]                  err_cnt,
    input  logic [31:0]                  period,
    input  logic [7:0]                   last_data,
    output logic                         enable,
    output logic                         clear_pulse,
    output logic [7:0]                   taps
);

    logic                         awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic                         enable_q, clear_q;
    logic [7:0]                   taps_q;
    logic [C_AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                         wr_accept, wr_fire, rd_accept, rd_fire;
    logic [7:0]                   wr_addr, rd_addr;
    logic                         unused_wdata;

    assign wr_addr   = 8'(s_axi_awaddr);
    assign rd_addr   = 8'(s_axi_araddr);
    assign wr_accept = s_axi_awvalid & s_axi_wvalid & ~awready_q & ~bvalid_q;
    assign wr_fire   = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_accept = s_axi_arvalid & ~arready_q & ~rvalid_q;
    assign rd_fire   = arready_q & s_axi_arvalid;

    assign unused_wdata = ^s_axi_wdata[C_AXIL_DATA_WIDTH-1:8];

    always_comb begin
        rdata_d = '0;
        case (rd_addr)
            AddrCtrl:      rdata_d[0]   = enable_q;
            AddrTaps:      rdata_d[7:0] = taps_q;
            AddrStatus:    rdata_d[2:0] = {err_sticky, first_seen, locked};
            AddrSampleCnt: rdata_d      = C_AXIL_DATA_WIDTH'(sample_cnt);
            AddrErrCnt:    rdata_d      = C_AXIL_DATA_WIDTH'(err_cnt);
            AddrPeriod:    rdata_d      = C_AXIL_DATA_WIDTH'(period);
            AddrLastData:  rdata_d[7:0] = last_data;
            default:       rdata_d      = '0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            enable_q  <= 1'b0;
            clear_q   <= 1'b0;
            taps_q    <= TapsReset;
        end else begin
            clear_q   <= 1'b0;
            // wr_accept requires awready low, so the ready pulse lasts one cycle.
            awready_q <= wr_accept;
            wready_q  <= wr_accept;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                case (wr_addr)
                    AddrCtrl: begin
                        enable_q <= s_axi_wdata[0];
                        clear_q  <= s_axi_wdata[1];
                    end
                    AddrTaps: taps_q <= s_axi_wdata[7:0];
                    default: ;
                endcase
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= rd_accept;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = RespOkay;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RespOkay;
    assign enable        = enable_q;
    assign clear_pulse   = clear_q;
    assign taps          = taps_q;

endmodule

// File: rtl/axis_lfsr_checker.sv
// AXI-Stream sink that checks an 8-bit LFSR stream against the programmed taps,
// counting samples and mismatches and measuring the sequence period.
module axis_lfsr_checker
    import axis_lfsr_checker_pkg::*;
#(
    parameter int unsigned C_AXIL_ADDR_WIDTH = 5,
    parameter int unsigned C_AXIL_DATA_WIDTH = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [C_AXIL_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [C_AXIL_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic [C_AXIL_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready
);

    logic       enable, clear_pulse;
    logic [7:0] taps;

    chk_state_e  state_q;
    logic [7:0]  first_val_q, expected_q, last_data_q;
    logic [31:0] sample_cnt_q, err_cnt_q, period_q;
    logic        locked_q, first_seen_q, err_sticky_q;
    logic [7:0]  beat;
    logic        beat_fire;
    logic        unused_tdata;

    assign s_axis_tready = enable & ~clear_pulse;
    assign beat          = s_axis_tdata[7:0];
    assign beat_fire     = s_axis_tvalid & s_axis_tready;
    assign unused_tdata  = ^s_axis_tdata[C_AXIL_DATA_WIDTH-1:8];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            first_val_q  <= '0;
            expected_q   <= '0;
            last_data_q  <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            period_q     <= '0;
            locked_q     <= 1'b0;
            first_seen_q <= 1'b0;
            err_sticky_q <= 1'b0;
        end else if (clear_pulse) begin
            state_q      <= enable ? StArm : StIdle;
            last_data_q  <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            period_q     <= '0;
            locked_q     <= 1'b0;
            first_seen_q <= 1'b0;
            err_sticky_q <= 1'b0;
        end else if (!enable) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                // A beat can already be accepted in the cycle enable rises, so IDLE
                // treats it exactly like ARM instead of dropping it.
                StIdle, StArm: begin
                    state_q <= StArm;
                    if (beat_fire) begin
                        first_val_q  <= beat;
                        expected_q   <= lfsr_step(beat, taps);
                        sample_cnt_q <= 32'd1;
                        first_seen_q <= 1'b1;
                        last_data_q  <= beat;
                        state_q      <= StTrack;
                    end
                end
                StTrack: begin
                    if (beat_fire) begin
                        if (sample_cnt_q != '1) sample_cnt_q <= sample_cnt_q + 32'd1;
                        last_data_q <= beat;
                        if (beat != expected_q) begin
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 32'd1;
                            err_sticky_q <= 1'b1;
                            expected_q   <= lfsr_step(beat, taps);
                        end else begin
                            expected_q <= lfsr_step(expected_q, taps);
                        end
                        if (beat == first_val_q && !locked_q) begin
                            period_q <= sample_cnt_q;
                            locked_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    axil_reg_slave #(
        .C_AXIL_ADDR_WIDTH(C_AXIL_ADDR_WIDTH),
        .C_AXIL_DATA_WIDTH(C_AXIL_DATA_WIDTH)
    ) u_regs (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .locked       (locked_q),
        .first_seen   (first_seen_q),
        .err_sticky   (err_sticky_q),
        .sample_cnt   (sample_cnt_q),
        .err_cnt      (err_cnt_q),
        .period       (period_q),
        .last_data    (last_data_q),
        .enable       (enable),
        .clear_pulse  (clear_pulse),
        .taps         (taps)
    );

endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Self-checking bench for axis_lfsr_checker: register tables, directed stream tables,
// handshake corner cases and randomized streams against a sequence-level model.
module tb_axis_lfsr_checker;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_TAPS   = 5'h04;
    localparam logic [4:0] A_STATUS = 5'h08;
    localparam logic [4:0] A_SAMPLE = 5'h0C;
    localparam logic [4:0] A_ERR    = 5'h10;
    localparam logic [4:0] A_PERIOD = 5'h14;
    localparam logic [4:0] A_LAST   = 5'h18;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [DW-1:0] tdata = '0;
    logic          tvalid = 1'b0;
    logic          tready;

    int vectors = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    axis_lfsr_checker #(
        .C_AXIL_ADDR_WIDTH(AW),
        .C_AXIL_DATA_WIDTH(DW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axi_awaddr (awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .s_axis_tdata (tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [7:0]       taps;
        int               n;
        logic [11:0][7:0] beats;
        logic [31:0]      exp_samples;
        logic [31:0]      exp_err;
        logic [31:0]      exp_period;
        logic [31:0]      exp_status;
        logic [31:0]      exp_last;
    } stream_vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    // Next LFSR value from the definition: shift left, append parity of tapped bits.
    function automatic logic [7:0] ref_next(input logic [7:0] d, input logic [7:0] t);
        int v;
        v = (int'(d) * 2) % 256 + ($countones(d & t) % 2);
        return 8'(v);
    endfunction

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
        bit ok;
        @(posedge aclk); #1;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (awready && wready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (!ok) check("write_accept_timeout", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (bvalid) begin ok = 1'b1; break; end
        end
        if (!ok) check("bvalid_timeout", 32'(ok), 32'd1);
        else if (bresp !== 2'b00) check("bresp", 32'(bresp), 32'd0);
        @(posedge aclk); #1;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        bit ok;
        d = 'x;
        @(posedge aclk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        if (!ok) check("read_accept_timeout", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (rvalid) begin ok = 1'b1; break; end
        end
        if (!ok) check("rvalid_timeout", 32'(ok), 32'd1);
        else begin
            d = rdata;
            if (rresp !== 2'b00) check("rresp", 32'(rresp), 32'd0);
        end
        @(posedge aclk); #1;
    endtask

    task automatic send_beat(input logic [7:0] d);
        bit ok;
        tdata = {24'($urandom), d};
        tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge aclk);
            if (tready) begin
                ok = 1'b1;
                @(posedge aclk); #1;
                break;
            end
            @(posedge aclk); #1;
        end
        tvalid = 1'b0;
        if (!ok) check("beat_timeout", 32'(ok), 32'd1);
    endtask

    task automatic check_results(input string tag, input logic [31:0] s, input logic [31:0] e,
                                 input logic [31:0] p, input logic [31:0] st,
                                 input logic [31:0] l);
        logic [31:0] rd;
        axi_read(A_SAMPLE, rd); check({tag, "_sample_cnt"}, rd, s);
        axi_read(A_ERR, rd);    check({tag, "_err_cnt"}, rd, e);
        axi_read(A_PERIOD, rd); check({tag, "_period"}, rd, p);
        axi_read(A_STATUS, rd); check({tag, "_status"}, rd, st);
        axi_read(A_LAST, rd);   check({tag, "_last_data"}, rd, l);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t     rst_tab[8];
        stream_vec_t str_tab[2];
        logic [31:0] rd;
        int          bad_a, bad_b;
        bit          saw_gap, ok;

        rst_tab[0] = '{A_CTRL,   32'h0};
        rst_tab[1] = '{A_TAPS,   32'hB8};
        rst_tab[2] = '{A_STATUS, 32'h0};
        rst_tab[3] = '{A_SAMPLE, 32'h0};
        rst_tab[4] = '{A_ERR,    32'h0};
        rst_tab[5] = '{A_PERIOD, 32'h0};
        rst_tab[6] = '{A_LAST,   32'h0};
        rst_tab[7] = '{5'h1C,    32'h0};

        str_tab[0].taps = 8'h80;
        str_tab[0].n    = 9;
        str_tab[0].beats = '0;
        for (int k = 0; k < 8; k++) str_tab[0].beats[k] = 8'(1 << k);
        str_tab[0].beats[8] = 8'h01;
        str_tab[0].exp_samples = 9;
        str_tab[0].exp_err     = 0;
        str_tab[0].exp_period  = 8;
        str_tab[0].exp_status  = 32'h3;
        str_tab[0].exp_last    = 32'h01;

        str_tab[1].taps = 8'h80;
        str_tab[1].n    = 4;
        str_tab[1].beats = '0;
        str_tab[1].beats[0] = 8'h01;
        str_tab[1].beats[1] = 8'h02;
        str_tab[1].beats[2] = 8'h05;
        str_tab[1].beats[3] = 8'h0A;
        str_tab[1].exp_samples = 4;
        str_tab[1].exp_err     = 1;
        str_tab[1].exp_period  = 0;
        str_tab[1].exp_status  = 32'h6;
        str_tab[1].exp_last    = 32'h0A;

        // Reset state.
        repeat (3) @(posedge aclk);
        #1;
        check("tready_in_reset", 32'(tready), 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("tready_after_reset", 32'(tready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            axi_read(rst_tab[i].addr, rd);
            check($sformatf("reset_read_%02h", rst_tab[i].addr), rd, rst_tab[i].exp);
        end

        // Directed stream tables.
        for (int i = 0; i < 2; i++) begin
            axi_write(A_TAPS, 32'(str_tab[i].taps));
            axi_write(A_CTRL, 32'h3);
            for (int k = 0; k < str_tab[i].n; k++) send_beat(str_tab[i].beats[k]);
            check_results($sformatf("table%0d", i), str_tab[i].exp_samples, str_tab[i].exp_err,
                          str_tab[i].exp_period, str_tab[i].exp_status, str_tab[i].exp_last);
        end

        // Disabled: tready stays low, nothing counted.
        axi_write(A_CTRL, 32'h0);
        tdata = 32'h0000_0004; tvalid = 1'b1;
        bad_a = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            if (tready) bad_a++;
            @(posedge aclk); #1;
        end
        tvalid = 1'b0;
        check("tready_high_while_disabled", 32'(bad_a), 32'd0);
        axi_read(A_SAMPLE, rd);
        check("sample_cnt_held_disabled", rd, 32'd4);

        // Clear together with a presented beat.
        axi_write(A_CTRL, 32'h1);
        send_beat(8'h11);
        send_beat(8'h22);
        tdata = 32'h0000_005A; tvalid = 1'b1;
        saw_gap = 1'b0;
        fork
            axi_write(A_CTRL, 32'h3);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge aclk);
                    if (!tready) begin saw_gap = 1'b1; break; end
                end
                @(posedge aclk); #1;
                tvalid = 1'b0;
            end
        join
        check("tready_low_in_clear_cycle", 32'(saw_gap), 32'd1);
        check_results("after_clear", 0, 0, 0, 0, 0);
        send_beat(8'h33);
        axi_read(A_SAMPLE, rd); check("arm_after_clear_sample", rd, 32'd1);
        axi_read(A_STATUS, rd); check("arm_after_clear_status", rd, 32'h2);
        axi_read(A_LAST, rd);   check("arm_after_clear_last", rd, 32'h33);

        // Back-to-back writes with the response stalled.
        @(posedge aclk); #1;
        bready = 1'b0;
        awaddr = A_TAPS; wdata = 32'h11; awvalid = 1'b1; wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (awready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        if (!ok) check("b2b_first_accept_timeout", 32'(ok), 32'd1);
        wdata = 32'h22;
        bad_a = 0; bad_b = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (awready) bad_a++;
            if (!bvalid) bad_b++;
            @(posedge aclk); #1;
        end
        check("b2b_awready_withheld", 32'(bad_a), 32'd0);
        check("b2b_bvalid_held", 32'(bad_b), 32'd0);
        bready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (awready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (!ok) check("b2b_second_accept_timeout", 32'(ok), 32'd1);
        repeat (3) begin @(posedge aclk); #1; end
        axi_read(A_TAPS, rd);
        check("b2b_taps_second_value", rd, 32'h22);

        // Randomized streams against the sequence-level model.
        for (int r = 0; r < 4; r++) begin
            logic [7:0]  t, cur;
            logic [7:0]  q[$];
            int          n, e_err, e_per;
            string       tag;
            case (r)
                0:       t = 8'h80;
                1:       t = 8'hB8;
                2:       t = 8'h8E;
                default: t = 8'($urandom);
            endcase
            n = $urandom_range(12, 40);
            q.delete();
            cur = 8'($urandom_range(1, 255));
            q.push_back(cur);
            for (int k = 1; k < n; k++) begin
                cur = ref_next(cur, t);
                if ($urandom_range(0, 7) == 0) cur = 8'($urandom);
                q.push_back(cur);
            end
            e_err = 0;
            e_per = 0;
            for (int k = 1; k < n; k++) begin
                if (q[k] != ref_next(q[k-1], t)) e_err++;
                if (e_per == 0 && q[k] == q[0]) e_per = k;
            end
            axi_write(A_TAPS, 32'(t));
            axi_write(A_CTRL, 32'h3);
            for (int k = 0; k < n; k++) begin
                send_beat(q[k]);
                repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            end
            tag = $sformatf("rand%0d", r);
            check_results(tag, 32'(n), 32'(e_err), 32'(e_per),
                          {29'd0, e_err != 0, 1'b1, e_per != 0}, 32'(q[n-1]));
        end

        // Asynchronous reset mid-stream with a read response pending.
        axi_write(A_CTRL, 32'h1);
        tdata = 32'h0000_0001; tvalid = 1'b1;
        rready = 1'b0;
        araddr = A_SAMPLE; arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        if (!ok) check("rst_read_accept_timeout", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (rvalid) begin ok = 1'b1; break; end
        end
        if (!ok) check("rst_rvalid_timeout", 32'(ok), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_reset_rvalid", 32'(rvalid), 32'd0);
        check("async_reset_tready", 32'(tready), 32'd0);
        check("async_reset_rdata", rdata, 32'd0);
        tvalid = 1'b0;
        rready = 1'b1;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        axi_read(A_CTRL, rd); check("post_reset_ctrl", rd, 32'h0);
        axi_read(A_TAPS, rd); check("post_reset_taps", rd, 32'hB8);
        check_results("post_reset", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_lfsr_checker.md
Name: axis_lfsr_checker

Overview:
- AXI-Stream sink that sits directly downstream of the 8-bit LFSR generator and consumes its m_axis stream.
- Recomputes each expected next value from the programmed taps, compares it with every received beat, and counts samples and mismatches.
- Measures the sequence period, i.e. the number of beats until the first value recurs.
- Exposes configuration and results through an AXI-Lite register slave. Serves as the self-check and monitor stage for the generator.

Parameters:
- C_AXIL_ADDR_WIDTH, 5, AXI-Lite address width (byte addresses 0x00-0x1F).
- C_AXIL_DATA_WIDTH, 32, AXI-Lite and AXI-Stream data width; only tdata[7:0] is checked.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; one clock; reset is asynchronous and active-low.
- s_axi_awaddr  in  C_AXIL_ADDR_WIDTH  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  C_AXIL_DATA_WIDTH  write data.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response, always 2'b00.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  C_AXIL_ADDR_WIDTH  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  C_AXIL_DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response, always 2'b00.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axis_tdata  in  C_AXIL_DATA_WIDTH  LFSR beat; bits [7:0] are significant.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat ready.

Behaviour:
- Reset: all outputs 0; registers 0 except TAPS=0xB8; FSM in IDLE.
- Register map:
  - 0x00 CTRL: [0] enable (R/W); [1] clear (write-1 pulse, reads 0).
  - 0x04 TAPS: [7:0], R/W.
  - 0x08 STATUS: [0] locked (period found); [1] first_seen; [2] err_sticky. Read-only.
  - 0x0C SAMPLE_CNT (RO). 0x10 ERR_CNT (RO). 0x14 PERIOD (RO). 0x18 LAST_DATA [7:0] (RO).
  - Unmapped addresses: writes are ignored; reads return 0; response is OKAY.
- AXI-Lite write:
  - Accepted only when awvalid and wvalid are both high, bvalid=0 and awready=0.
  - awready/wready pulse high for exactly 1 cycle; the register updates on that edge.
  - bvalid rises on the next cycle and is held until bready, then clears.
  - No new write is accepted while bvalid=1.
- AXI-Lite read:
  - Accepted when arvalid=1, rvalid=0 and arready=0; arready pulses for 1 cycle.
  - rdata is registered from araddr in that same cycle; rvalid rises on the next edge and is held, with rdata stable, until rready.
  - A read coinciding with a counter update returns the pre-update value.
- Stream handshake:
  - s_axis_tready = enable & ~clear_pulse.
  - A beat transfers when tvalid & tready are both high.
- FSM:
  - IDLE: enable=0. Counters and status hold.
  - enable 0->1 goes to ARM.
  - ARM: the first accepted beat d sets first_val=d, expected=step(d), SAMPLE_CNT=1, first_seen=1, LAST_DATA=d; go to TRACK.
  - TRACK, on each accepted beat d:
    - SAMPLE_CNT++ and LAST_DATA=d.
    - If d!=expected: ERR_CNT++, err_sticky=1; expected resyncs to step(d).
    - Else: expected=step(expected).
    - If d==first_val and locked=0: PERIOD = beats since the first beat (SAMPLE_CNT before increment); locked=1.
  - enable 1->0 from any state goes to IDLE. Re-enabling re-enters ARM; counters are not cleared.
- step(d) = {d[6:0], ^(TAPS & d)}. A TAPS write takes effect on the next computed expected value.
- clear pulse:
  - Zeroes SAMPLE_CNT, ERR_CNT, PERIOD, LAST_DATA and all status bits.
  - Returns the FSM to ARM if enable=1, otherwise IDLE.
  - A beat presented in the clear cycle is not accepted (tready is low). Clear wins over any simultaneous event.
- SAMPLE_CNT and ERR_CNT saturate at 0xFFFF_FFFF.
- Asynchronous reset mid-transaction aborts any pending bvalid/rvalid; everything returns to reset values immediately.

Decomposition:
- Shared package holds:
  - register offsets: CTRL, TAPS, STATUS, SAMPLE_CNT, ERR_CNT, PERIOD, LAST_DATA;
  - TAPS reset value 0xB8;
  - RESP_OKAY;
  - the FSM state encoding: IDLE, ARM, TRACK;
  - the lfsr_step function, shared with the generator.
- One sub-module: axil_reg_slave. It implements the AXI-Lite handshake and register file and exports enable, clear_pulse and taps. The checker core stays in the top level.

Test Plan:
- Reset, then read all registers -> TAPS=0xB8, all others 0, s_axis_tready=0.
- TAPS=0x80, enable=1, stream 0x01,0x02,...,0x80,0x01 (9 beats) -> SAMPLE_CNT=9, ERR_CNT=0, PERIOD=8, STATUS=0x3.
- TAPS=0x80, stream 0x01,0x02,0x05,0x0A -> ERR_CNT=1, err_sticky=1, LAST_DATA=0x0A. The 0x0A beat matches the resynced expected value, so no further error.
- enable=0 with tvalid held high -> tready=0, no counts. Write clear together with a tvalid beat -> beat not accepted, all counters 0, FSM in ARM.
- Back-to-back writes with bready held low for 5 cycles -> second awready withheld until bvalid clears. Read of 0x1C -> rdata=0, rresp=0.
- Assert aresetn=0 mid-stream and while rvalid=1 -> rvalid=0 and all counters 0 immediately, without waiting for a clock edge.
